// File: rtl/shim_threshold_integrator.sv
// Per-channel |sample| window integrator with a latched over-threshold fault.
// Runs in the SPI clock domain from stable config inputs and feeds shim shutdown.
module shim_threshold_integrator #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned MIN_WINDOW = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    spi_en,
    input  logic                    integ_en,
    input  logic [31:0]             integ_window,
    input  logic [14:0]             integ_thresh_avg,
    input  logic                    sample_valid,
    input  logic [CHANNELS*16-1:0]  sample_data,
    output logic                    integ_running,
    output logic                    window_done,
    output logic                    over_thresh,
    output logic [CHANNELS-1:0]     over_thresh_mask,
    output logic                    err_window
);

    localparam int unsigned AccW = 47;

    typedef enum logic [2:0] {StIdle, StSetup, StRun, StFault, StErr} state_e;

    state_e              state_q, state_d;
    logic [31:0]         window_q, window_d;
    logic [14:0]         thr_q, thr_d;
    logic [AccW-1:0]     limit_q, limit_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [AccW-1:0]     acc_q [CHANNELS];
    logic [AccW-1:0]     acc_d [CHANNELS];
    logic [AccW-1:0]     snap_q [CHANNELS];
    logic [AccW-1:0]     snap_d [CHANNELS];
    logic                cmp_pend_q, cmp_pend_d;
    logic                window_done_q, window_done_d;
    logic                over_q, over_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                err_q, err_d;

    logic                enable;
    logic [14:0]         abs_sat [CHANNELS];
    logic [CHANNELS-1:0] over_vec;

    assign enable = spi_en & integ_en;

    // Saturating magnitude: -32768 clamps to 32767 so it fits in 15 bits.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            abs_sat[ch] = 15'd0;
            if (sample_data[16*ch+15]) begin
                if (sample_data[16*ch +: 15] == 15'd0) begin
                    abs_sat[ch] = 15'h7fff;
                end else begin
                    abs_sat[ch] = ~sample_data[16*ch +: 15] + 15'd1;
                end
            end else begin
                abs_sat[ch] = sample_data[16*ch +: 15];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            over_vec[ch] = snap_q[ch] > limit_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        window_d      = window_q;
        thr_d         = thr_q;
        limit_d       = limit_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        snap_d        = snap_q;
        cmp_pend_d    = cmp_pend_q;
        window_done_d = 1'b0;
        over_d        = over_q;
        mask_d        = mask_q;
        err_d         = err_q;

        if (!enable) begin
            // Dropping enable abandons any partial window without a done pulse.
            state_d    = StIdle;
            cnt_d      = '0;
            cmp_pend_d = 1'b0;
            over_d     = 1'b0;
            mask_d     = '0;
            err_d      = 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_d[ch]  = '0;
                snap_d[ch] = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        acc_d[ch]  = '0;
                        snap_d[ch] = '0;
                    end
                    if (integ_window < 32'(MIN_WINDOW)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        window_d = integ_window;
                        thr_d    = integ_thresh_avg;
                        state_d  = StSetup;
                    end
                end
                StSetup: begin
                    limit_d = AccW'(thr_q) * AccW'(window_q);
                    state_d = StRun;
                end
                StRun: begin
                    if (cmp_pend_q) begin
                        cmp_pend_d    = 1'b0;
                        window_done_d = 1'b1;
                        if (|over_vec) begin
                            mask_d  = over_vec;
                            over_d  = 1'b1;
                            state_d = StFault;
                        end
                    end
                    if (sample_valid) begin
                        if (cnt_q == window_q - 32'd1) begin
                            // Last frame of the window goes straight into the snapshot.
                            cnt_d      = '0;
                            cmp_pend_d = 1'b1;
                            for (int ch = 0; ch < CHANNELS; ch++) begin
                                snap_d[ch] = acc_q[ch] + AccW'(abs_sat[ch]);
                                acc_d[ch]  = '0;
                            end
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                            for (int ch = 0; ch < CHANNELS; ch++) begin
                                acc_d[ch] = acc_q[ch] + AccW'(abs_sat[ch]);
                            end
                        end
                    end
                end
                StFault: ;
                StErr:   ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            window_q      <= '0;
            thr_q         <= '0;
            limit_q       <= '0;
            cnt_q         <= '0;
            cmp_pend_q    <= 1'b0;
            window_done_q <= 1'b0;
            over_q        <= 1'b0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch]  <= '0;
                snap_q[ch] <= '0;
            end
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            thr_q         <= thr_d;
            limit_q       <= limit_d;
            cnt_q         <= cnt_d;
            cmp_pend_q    <= cmp_pend_d;
            window_done_q <= window_done_d;
            over_q        <= over_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch]  <= acc_d[ch];
                snap_q[ch] <= snap_d[ch];
            end
        end
    end

    assign integ_running    = (state_q == StRun);
    assign window_done      = window_done_q;
    assign over_thresh      = over_q;
    assign over_thresh_mask = mask_q;
    assign err_window       = err_q;

endmodule

// File: tb/tb_shim_threshold_integrator.sv
// Scoreboard bench for shim_threshold_integrator: a per-window arithmetic model
// predicts each window_done and its fault verdict; a monitor checks them.
module tb_shim_threshold_integrator;

    localparam int NCH = 8;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           spi_en = 1'b0;
    logic           integ_en = 1'b0;
    logic [31:0]    integ_window = 32'd0;
    logic [14:0]    integ_thresh_avg = 15'd0;
    logic           sample_valid = 1'b0;
    logic [NCH*16-1:0] sample_data = '0;
    logic           integ_running;
    logic           window_done;
    logic           over_thresh;
    logic [NCH-1:0] over_thresh_mask;
    logic           err_window;

    shim_threshold_integrator #(.CHANNELS(NCH), .MIN_WINDOW(4)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .spi_en           (spi_en),
        .integ_en         (integ_en),
        .integ_window     (integ_window),
        .integ_thresh_avg (integ_thresh_avg),
        .sample_valid     (sample_valid),
        .sample_data      (sample_data),
        .integ_running    (integ_running),
        .window_done      (window_done),
        .over_thresh      (over_thresh),
        .over_thresh_mask (over_thresh_mask),
        .err_window       (err_window)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH-1:0] mask;
        int             cyc;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: windows of plain integer sums, judged against thr*window.
    longint m_sum [NCH];
    int     m_frames;
    int     m_win;
    int     m_thr;
    bit     m_faulted;

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) m_sum[c] = 0;
        m_frames  = 0;
        m_faulted = 0;
    endtask

    function automatic logic [NCH*16-1:0] fill(input int v);
        logic [NCH*16-1:0] d;
        for (int c = 0; c < NCH; c++) d[16*c +: 16] = 16'(v);
        return d;
    endfunction

    task automatic send_frame(input logic [NCH*16-1:0] d);
        exp_t e;
        logic signed [15:0] s;
        int x;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
        if (!m_faulted) begin
            for (int c = 0; c < NCH; c++) begin
                s = d[16*c +: 16];
                x = s;
                m_sum[c] += (x == -32768) ? 32767 : ((x < 0) ? -x : x);
            end
            m_frames++;
            if (m_frames == m_win) begin
                e.mask = '0;
                for (int c = 0; c < NCH; c++) begin
                    if (m_sum[c] > longint'(m_thr) * longint'(m_win)) e.mask[c] = 1'b1;
                    m_sum[c] = 0;
                end
                e.cyc = cyc + 2;
                exp_q.push_back(e);
                m_frames = 0;
                if (e.mask != '0) m_faulted = 1;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Junk frames during the IDLE and SETUP edges must not be counted.
    task automatic start(input int win, input int thr);
        @(negedge clk);
        integ_window     = 32'(win);
        integ_thresh_avg = 15'(thr);
        spi_en           = 1'b1;
        integ_en         = 1'b1;
        sample_valid     = 1'b1;
        sample_data      = fill(-32768);
        m_win = win;
        m_thr = thr;
        model_clear();
        @(negedge clk);
        sample_data = fill(30000);
    endtask

    task automatic drain(input string name);
        repeat (3) idle_cycle();
        chk({name, "_pending_windows"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic stop(input bit drop_spi);
        @(negedge clk);
        if (drop_spi) spi_en = 1'b0;
        else integ_en = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("disable_over_thresh", over_thresh, 0);
        chk("disable_mask", over_thresh_mask, 0);
        chk("disable_err", err_window, 0);
        chk("disable_running", integ_running, 0);
        model_clear();
    endtask

    always @(negedge clk) begin
        if (aresetn && window_done) begin
            if (exp_q.size() == 0) begin
                chk("window_done_unexpected", window_done, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("window_done_cycle", cyc, e.cyc);
                chk("window_over_thresh", over_thresh, (e.mask != '0) ? 1 : 0);
                chk("window_mask", over_thresh_mask, e.mask);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*16-1:0] d;
        int win, thr, amp, nfr, x;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outputs", {integ_running, window_done, over_thresh,
                              over_thresh_mask, err_window}, 0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {integ_running, over_thresh, err_window}, 0);

        // Sum equal to limit is not a fault
        start(4, 100);
        for (int i = 0; i < 12; i++) send_frame(fill(100));
        drain("t1");
        chk("t1_running", integ_running, 1);
        chk("t1_over_thresh", over_thresh, 0);
        stop(1'b0);

        // Single channel over the limit; later frames ignored
        start(4, 100);
        d = fill(0);
        d[16*3 +: 16] = 16'hff9b;
        for (int i = 0; i < 8; i++) send_frame(d);
        drain("t2");
        chk("t2_running", integ_running, 0);
        chk("t2_over_thresh", over_thresh, 1);
        chk("t2_mask", over_thresh_mask, 8'h08);
        stop(1'b0);

        // Saturation of -32768
        d = fill(0);
        d[15:0] = 16'h8000;
        start(16, 32767);
        for (int i = 0; i < 16; i++) send_frame(d);
        drain("t3a");
        chk("t3a_over_thresh", over_thresh, 0);
        stop(1'b1);
        start(16, 32766);
        for (int i = 0; i < 16; i++) send_frame(d);
        drain("t3b");
        chk("t3b_mask", over_thresh_mask, 8'h01);
        stop(1'b1);

        // Window below minimum
        @(negedge clk);
        integ_window = 32'd3;
        spi_en = 1'b1;
        integ_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_err_window", err_window, 1);
            chk("t4_running", integ_running, 0);
        end
        integ_en = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", err_window, 0);

        // Asynchronous reset mid-window
        start(4, 100);
        send_frame(fill(10));
        send_frame(fill(10));
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t5_running_before", integ_running, 1);
        #2 aresetn = 1'b0;
        #1 chk("t5_reset_outputs", {integ_running, window_done, over_thresh,
                                    over_thresh_mask, err_window}, 0);
        model_clear();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = fill(500);
        aresetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_frame(fill(10));
        drain("t5");
        stop(1'b0);

        // Config change in RUN ignored until re-enable
        start(4, 100);
        send_frame(fill(50));
        send_frame(fill(50));
        integ_window = 32'd8;
        for (int i = 0; i < 6; i++) send_frame(fill(50));
        d = fill(0);
        d[16*6 +: 16] = 16'd200;
        for (int i = 0; i < 4; i++) send_frame(d);
        drain("t6a");
        chk("t6_over_thresh", over_thresh, 1);
        stop(1'b1);
        start(8, 100);
        for (int i = 0; i < 16; i++) send_frame(fill(100));
        drain("t6b");
        stop(1'b1);

        // Random windows, thresholds and samples with valid gaps
        for (int run = 0; run < 8; run++) begin
            win = $urandom_range(10, 4);
            thr = $urandom_range(30000, 2000);
            amp = $urandom_range(32767, thr / 2);
            nfr = win * 3 + int'($urandom_range(win - 1, 0));
            start(win, thr);
            for (int f = 0; f < nfr; f++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(31, 0) == 0) x = -32768;
                    else x = int'($urandom_range(2 * amp, 0)) - amp;
                    d[16*c +: 16] = 16'(x);
                end
                send_frame(d);
                if ($urandom_range(3, 0) == 0) idle_cycle();
            end
            drain("rand");
            stop($urandom_range(1, 0) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
